sync_fifo_buffer: RTL and testbench

//   Single-clock FIFO that keeps the dInACK/dInREQ/dOutACK/dOutREQ handshake of our CDC FIFO.

---
 rtl/sync_fifo_buffer_pkg.sv | 17 +
 rtl/fifo_sync_pointer.sv | 32 +++
 rtl/sync_fifo_buffer.sv | 145 ++++++++++++++
 tb/tb_sync_fifo_buffer.sv | 220 ++++++++++++++++++++++
 4 files changed

// File: rtl/sync_fifo_buffer_pkg.sv
// rtl/sync_fifo_buffer_pkg.sv - shared types and defaults for the single-clock FIFO
// Purpose: output-mode encoding and default parameter values used by the FIFO files.
// Ports:   none (package)
package sync_fifo_buffer_pkg;

   typedef enum logic {
      OUT_FWFT = 1'b0,
      OUT_REG  = 1'b1
   } out_mode_e;

   localparam int DEF_BITWIDTH  = 8;
   localparam int DEF_DEPTH     = 16;
   localparam int DEF_OUTREG    = 0;
   localparam int DEF_AF_THRESH = 12;
   localparam int DEF_AE_THRESH = 2;

endpackage

// File: rtl/fifo_sync_pointer.sv
// rtl/fifo_sync_pointer.sv - binary wrap pointer for the single-clock FIFO
// Purpose: ADDRWIDTH+1 bit binary counter; the extra MSB toggles on every wrap so
//          equal low bits with differing MSBs distinguish full from empty.
// Ports:   clk, rst (async active-low), flush (sync clear), Count_en (advance),
//          Pointer (current value)
module fifo_sync_pointer
   import sync_fifo_buffer_pkg::*;
#(
   parameter int ADDRWIDTH = 4
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 flush,
   input  logic                 Count_en,
   output logic [ADDRWIDTH:0]   Pointer
);

   localparam logic [ADDRWIDTH:0] PTR_ONE = {{ADDRWIDTH{1'b0}}, 1'b1};

   // DEPTH is a power of two, so natural overflow of the low bits is the wrap
   // and the carry into the MSB is the wrap toggle.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         Pointer <= '0;
      end else if (flush) begin
         Pointer <= '0;
      end else if (Count_en) begin
         Pointer <= Pointer + PTR_ONE;
      end
   end

endmodule

// File: rtl/sync_fifo_buffer.sv
// rtl/sync_fifo_buffer.sv - single-clock FIFO with REQ/ACK handshake and status flags
// Purpose: intra-domain buffer, FWFT or registered output, occupancy count,
//          almost-full/almost-empty flags, synchronous flush and high-water mark.
// Ports:   clk, rst (async active-low), flush (sync clear)
//          dInACK/dInREQ/dIN     producer side (push = dInACK & dInREQ)
//          dOutACK/dOutREQ/dOUT  consumer side (pop = dOutACK & dOutREQ), dOUT=0 when idle
//          Count, AlmostFull, AlmostEmpty, HighWater  status
module sync_fifo_buffer
   import sync_fifo_buffer_pkg::*;
#(
   parameter int BITWIDTH  = DEF_BITWIDTH,
   parameter int DEPTH     = DEF_DEPTH,
   parameter int OUTREG    = DEF_OUTREG,
   parameter int AF_THRESH = DEF_AF_THRESH,
   parameter int AE_THRESH = DEF_AE_THRESH
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      flush,
   input  logic                      dInACK,
   output logic                      dInREQ,
   input  logic [BITWIDTH-1:0]       dIN,
   output logic                      dOutACK,
   input  logic                      dOutREQ,
   output logic [BITWIDTH-1:0]       dOUT,
   output logic [$clog2(DEPTH):0]    Count,
   output logic                      AlmostFull,
   output logic                      AlmostEmpty,
   output logic [$clog2(DEPTH):0]    HighWater
);

   localparam int ADDRWIDTH = $clog2(DEPTH);
   localparam int CW        = ADDRWIDTH + 1;
   localparam out_mode_e MODE = (OUTREG != 0) ? OUT_REG : OUT_FWFT;

   localparam logic [ADDRWIDTH:0] CNT_ONE = {{ADDRWIDTH{1'b0}}, 1'b1};
   localparam logic [ADDRWIDTH:0] AF_LIM  = CW'(AF_THRESH);
   localparam logic [ADDRWIDTH:0] AE_LIM  = CW'(AE_THRESH);

   logic [ADDRWIDTH:0]   wr_ptr;
   logic [ADDRWIDTH:0]   rd_ptr;
   logic                 arr_empty;
   logic                 full;
   logic                 push;
   logic                 pop;
   logic                 wr_en;
   logic                 rd_adv;
   logic [ADDRWIDTH:0]   count_next;
   logic [BITWIDTH-1:0]  mem [DEPTH];

   // Status of the storage array alone; the output register never counts toward Full.
   assign arr_empty = (wr_ptr == rd_ptr);
   assign full      = (wr_ptr[ADDRWIDTH] != rd_ptr[ADDRWIDTH]) &&
                      (wr_ptr[ADDRWIDTH-1:0] == rd_ptr[ADDRWIDTH-1:0]);

   assign dInREQ = ~full;
   assign push   = dInACK & ~full;
   // Flush drops any word offered in the same cycle.
   assign wr_en  = push & ~flush;

   fifo_sync_pointer #(.ADDRWIDTH(ADDRWIDTH)) u_wr_ptr (
      .clk      (clk),
      .rst      (rst),
      .flush    (flush),
      .Count_en (wr_en),
      .Pointer  (wr_ptr)
   );

   fifo_sync_pointer #(.ADDRWIDTH(ADDRWIDTH)) u_rd_ptr (
      .clk      (clk),
      .rst      (rst),
      .flush    (flush),
      .Count_en (rd_adv),
      .Pointer  (rd_ptr)
   );

   // Storage is deliberately unreset; only pointers define what is valid.
   always_ff @(posedge clk) begin
      if (wr_en) begin
         mem[wr_ptr[ADDRWIDTH-1:0]] <= dIN;
      end
   end

   if (MODE == OUT_REG) begin : g_outreg
      logic                out_valid;
      logic [BITWIDTH-1:0] out_data;
      logic                load;

      // Refill the output stage whenever it is empty or being drained this cycle.
      assign load    = (~out_valid | pop) & ~arr_empty;
      assign rd_adv  = load & ~flush;
      assign pop     = out_valid & dOutREQ;
      assign dOutACK = out_valid;
      assign dOUT    = out_valid ? out_data : '0;

      always_ff @(posedge clk or negedge rst) begin
         if (!rst) begin
            out_valid <= 1'b0;
            out_data  <= '0;
         end else if (flush) begin
            out_valid <= 1'b0;
         end else if (load) begin
            out_valid <= 1'b1;
            out_data  <= mem[rd_ptr[ADDRWIDTH-1:0]];
         end else if (pop) begin
            out_valid <= 1'b0;
         end
      end
   end else begin : g_fwft
      assign rd_adv  = pop & ~flush;
      assign pop     = ~arr_empty & dOutREQ;
      assign dOutACK = ~arr_empty;
      assign dOUT    = arr_empty ? '0 : mem[rd_ptr[ADDRWIDTH-1:0]];
   end

   // A move from array to output register leaves Count unchanged; only the
   // external push/pop handshakes move it.
   always_comb begin
      count_next = Count;
      if (push && !pop) begin
         count_next = Count + CNT_ONE;
      end else if (!push && pop) begin
         count_next = Count - CNT_ONE;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         Count     <= '0;
         HighWater <= '0;
      end else if (flush) begin
         Count     <= '0;
         HighWater <= '0;
      end else begin
         Count <= count_next;
         if (count_next > HighWater) begin
            HighWater <= count_next;
         end
      end
   end

   assign AlmostFull  = (Count >= AF_LIM);
   assign AlmostEmpty = (Count <= AE_LIM);

endmodule

// File: tb/tb_sync_fifo_buffer.sv
// tb/tb_sync_fifo_buffer.sv - self-checking bench for sync_fifo_buffer (FWFT and registered)
module tb_sync_fifo_buffer;

   localparam int DEPTH = 16;
   localparam int AF    = 12;
   localparam int AE    = 2;

   logic clk = 1'b0;
   logic rst = 1'b0;
   logic flush = 1'b0;

   logic       f_ack = 0, f_req_in = 0, f_oreq = 0;
   logic [7:0] f_din = 0, f_dout;
   logic       f_oack, f_af, f_ae;
   logic [4:0] f_cnt, f_hw;

   logic       r_ack = 0, r_req_in = 0, r_oreq = 0;
   logic [7:0] r_din = 0, r_dout;
   logic       r_oack, r_af, r_ae;
   logic [4:0] r_cnt, r_hw;

   always #5 clk = ~clk;

   sync_fifo_buffer #(.BITWIDTH(8), .DEPTH(DEPTH), .OUTREG(0), .AF_THRESH(AF), .AE_THRESH(AE)) u_fwft (
      .clk(clk), .rst(rst), .flush(flush),
      .dInACK(f_ack), .dInREQ(f_req_in), .dIN(f_din),
      .dOutACK(f_oack), .dOutREQ(f_oreq), .dOUT(f_dout),
      .Count(f_cnt), .AlmostFull(f_af), .AlmostEmpty(f_ae), .HighWater(f_hw)
   );

   sync_fifo_buffer #(.BITWIDTH(8), .DEPTH(DEPTH), .OUTREG(1), .AF_THRESH(AF), .AE_THRESH(AE)) u_reg (
      .clk(clk), .rst(rst), .flush(flush),
      .dInACK(r_ack), .dInREQ(r_req_in), .dIN(r_din),
      .dOutACK(r_oack), .dOutREQ(r_oreq), .dOUT(r_dout),
      .Count(r_cnt), .AlmostFull(r_af), .AlmostEmpty(r_ae), .HighWater(r_hw)
   );

   int errors = 0;
   int checks = 0;

   // Reference model: a FIFO is a queue of words; the registered variant also
   // tracks whether its head word has reached the visible output slot.
   logic [7:0] fq[$];
   int         fhw;
   logic [7:0] rq[$];
   bit         rov;
   int         rhw;

   task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic model_clear();
      fq.delete(); fhw = 0;
      rq.delete(); rov = 0; rhw = 0;
   endtask

   task automatic model_edge(input bit fa, input bit fr, input logic [7:0] fd,
                             input bit ra, input bit rr, input logic [7:0] rd, input bit fl);
      int  arr;
      bit  p, pp, nov;
      if (fl) begin
         model_clear();
         return;
      end
      p  = fa && (fq.size() < DEPTH);
      pp = fr && (fq.size() > 0);
      if (pp) void'(fq.pop_front());
      if (p) fq.push_back(fd);
      if (fq.size() > fhw) fhw = fq.size();

      arr = rq.size() - int'(rov);
      p   = ra && (arr < DEPTH);
      pp  = rov && rr;
      nov = (arr > 0) ? 1'b1 : (rov && !pp);
      if (pp) void'(rq.pop_front());
      if (p) rq.push_back(rd);
      rov = nov;
      if (rq.size() > rhw) rhw = rq.size();
   endtask

   task automatic check_all();
      int fs, rs;
      fs = fq.size();
      rs = rq.size();
      check_eq("f_dInREQ",  32'(f_req_in), 32'(fs < DEPTH));
      check_eq("f_dOutACK", 32'(f_oack),   32'(fs > 0));
      check_eq("f_dOUT",    32'(f_dout),   (fs > 0) ? 32'(fq[0]) : 32'd0);
      check_eq("f_Count",   32'(f_cnt),    32'(fs));
      check_eq("f_AF",      32'(f_af),     32'(fs >= AF));
      check_eq("f_AE",      32'(f_ae),     32'(fs <= AE));
      check_eq("f_HW",      32'(f_hw),     32'(fhw));
      check_eq("r_dInREQ",  32'(r_req_in), 32'((rs - int'(rov)) < DEPTH));
      check_eq("r_dOutACK", 32'(r_oack),   32'(rov));
      check_eq("r_dOUT",    32'(r_dout),   rov ? 32'(rq[0]) : 32'd0);
      check_eq("r_Count",   32'(r_cnt),    32'(rs));
      check_eq("r_AF",      32'(r_af),     32'(rs >= AF));
      check_eq("r_AE",      32'(r_ae),     32'(rs <= AE));
      check_eq("r_HW",      32'(r_hw),     32'(rhw));
   endtask

   // Entered and left at a negedge: drive inputs, take the edge, update model, check.
   task automatic cycle(input bit fa, input bit fr, input logic [7:0] fd,
                        input bit ra, input bit rr, input logic [7:0] rd, input bit fl);
      f_ack = fa; f_oreq = fr; f_din = fd;
      r_ack = ra; r_oreq = rr; r_din = rd;
      flush = fl;
      @(posedge clk);
      model_edge(fa, fr, fd, ra, rr, rd, fl);
      @(negedge clk);
      f_ack = 0; f_oreq = 0; r_ack = 0; r_oreq = 0; flush = 0;
      check_all();
   endtask

   task automatic do_reset();
      f_ack = 0; f_oreq = 0; r_ack = 0; r_oreq = 0; flush = 0;
      rst = 0;
      @(posedge clk);
      #1;
      model_clear();
      check_eq("rst_dInREQ",  32'(f_req_in), 32'd1);
      check_eq("rst_dOutACK", 32'(f_oack),   32'd0);
      check_eq("rst_dOUT",    32'(f_dout),   32'd0);
      check_eq("rst_AE",      32'(f_ae),     32'd1);
      check_eq("rst_AF",      32'(f_af),     32'd0);
      check_eq("rst_r_oack",  32'(r_oack),   32'd0);
      @(negedge clk);
      rst = 1;
   endtask

   initial begin
      model_clear();
      do_reset();

      // 1: single push into empty FWFT becomes visible next cycle
      cycle(1, 0, 8'h11, 0, 0, 8'h00, 0);
      check_eq("t1_oack", 32'(f_oack), 32'd1);
      check_eq("t1_dout", 32'(f_dout), 32'h11);
      check_eq("t1_cnt",  32'(f_cnt),  32'd1);
      check_eq("t1_ae",   32'(f_ae),   32'd1);

      // 2: fill to full, refused 17th push, drain in order
      do_reset();
      for (int i = 0; i < 17; i++) cycle(1, 0, 8'(i), 0, 0, 8'h00, 0);
      check_eq("t2_req", 32'(f_req_in), 32'd0);
      check_eq("t2_cnt", 32'(f_cnt),    32'd16);
      check_eq("t2_af",  32'(f_af),     32'd1);
      check_eq("t2_hw",  32'(f_hw),     32'd16);
      for (int i = 0; i < 16; i++) begin
         check_eq("t2_order", 32'(f_dout), 32'(i));
         cycle(0, 1, 8'h00, 0, 0, 8'h00, 0);
      end
      check_eq("t2_dout0", 32'(f_dout), 32'd0);

      // 3: steady state at Count=8 while pointers wrap
      do_reset();
      for (int i = 0; i < 8; i++) cycle(1, 0, 8'(8'h40 + i), 0, 0, 8'h00, 0);
      for (int i = 0; i < 40; i++) cycle(1, 1, 8'(8'h80 + i), 0, 0, 8'h00, 0);
      check_eq("t3_cnt", 32'(f_cnt), 32'd8);

      // 4: registered output latency and capacity DEPTH+1
      do_reset();
      cycle(0, 0, 8'h00, 1, 0, 8'hA5, 0);
      check_eq("t4_lat1", 32'(r_oack), 32'd0);
      cycle(0, 0, 8'h00, 0, 0, 8'h00, 0);
      check_eq("t4_lat2", 32'(r_oack), 32'd1);
      check_eq("t4_dout", 32'(r_dout), 32'hA5);
      for (int i = 0; i < 17; i++) cycle(0, 0, 8'h00, 1, 0, 8'(i), 0);
      check_eq("t4_req", 32'(r_req_in), 32'd0);
      check_eq("t4_cnt", 32'(r_cnt),    32'd17);

      // 5: flush overrides simultaneous push and pop
      do_reset();
      for (int i = 0; i < 10; i++) cycle(1, 0, 8'(i), 1, 0, 8'(i), 0);
      cycle(1, 1, 8'hEE, 1, 1, 8'hEE, 1);
      check_eq("t5_cnt",  32'(f_cnt),    32'd0);
      check_eq("t5_oack", 32'(f_oack),   32'd0);
      check_eq("t5_hw",   32'(f_hw),     32'd0);
      check_eq("t5_req",  32'(f_req_in), 32'd1);
      check_eq("t5_rcnt", 32'(r_cnt),    32'd0);

      // 6: asynchronous reset between edges, then fresh push
      do_reset();
      for (int i = 0; i < 5; i++) cycle(1, 0, 8'(i + 1), 1, 0, 8'(i + 1), 0);
      #2;
      rst = 0;
      #1;
      check_eq("t6_oack", 32'(f_oack), 32'd0);
      check_eq("t6_cnt",  32'(f_cnt),  32'd0);
      check_eq("t6_rcnt", 32'(r_cnt),  32'd0);
      model_clear();
      @(negedge clk);
      rst = 1;
      cycle(1, 0, 8'h3C, 1, 0, 8'h3C, 0);
      cycle(0, 0, 8'h00, 0, 0, 8'h00, 0);
      check_eq("t6_dout",  32'(f_dout), 32'h3C);
      check_eq("t6_rdout", 32'(r_dout), 32'h3C);

      // Randomized traffic with varying fill/drain bias and occasional flush
      do_reset();
      for (int seg = 0; seg < 14; seg++) begin
         int pw, pr;
         pw = int'($urandom_range(10, 90));
         pr = int'($urandom_range(10, 90));
         for (int c = 0; c < 50; c++) begin
            cycle(int'($urandom_range(99)) < pw, int'($urandom_range(99)) < pr, 8'($urandom),
                  int'($urandom_range(99)) < pw, int'($urandom_range(99)) < pr, 8'($urandom),
                  $urandom_range(199) == 0);
         end
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
